// File: rtl/drum_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drum_step_sequencer_pkg
//  Brief    : Shared state encoding, default sizing and FSM transition helper
//             for the drum step sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package drum_step_sequencer_pkg;

    localparam int DEF_NUM_STEPS      = 16;
    localparam int DEF_NUM_VOICES     = 4;
    localparam int DEF_TICKS_PER_STEP = 4;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_RUN   = 2'd1;
    localparam logic [1:0] C_ST_PAUSE = 2'd2;

    typedef struct packed {
        logic start;
        logic stop;
        logic pause;
    } ctrl_t;

    // Only the highest-priority pulse (stop > pause > start) is acted upon.
    function automatic logic [1:0] next_state(input logic [1:0] cur, input ctrl_t ctrl);
        logic [1:0] nxt;
        nxt = cur;
        if (ctrl.stop) begin
            nxt = C_ST_IDLE;
        end else if (ctrl.pause) begin
            if (cur == C_ST_RUN) nxt = C_ST_PAUSE;
        end else if (ctrl.start) begin
            if (cur == C_ST_IDLE || cur == C_ST_PAUSE) nxt = C_ST_RUN;
        end
        if (nxt != C_ST_RUN && nxt != C_ST_PAUSE) nxt = C_ST_IDLE;
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tick_edge_sync
//  Brief    : Two-flop synchronizer plus registered rising-edge detector.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_edge_sync (
    input  logic clk_rx,
    input  logic rst,
    input  logic tick_in,
    output logic tick_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= tick_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign tick_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/drum_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : drum_step_sequencer
//  Brief    : Pattern-driven drum step sequencer with run/pause/stop control.
//  Revision : 1.0 - initial release
// ============================================================================
module drum_step_sequencer
    import drum_step_sequencer_pkg::*;
#(
    parameter int NUM_STEPS      = DEF_NUM_STEPS,
    parameter int NUM_VOICES     = DEF_NUM_VOICES,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP
) (
    input  logic                         clk_rx,
    input  logic                         rst,
    input  logic                         tick_in,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         pat_we,
    input  logic [$clog2(NUM_STEPS)-1:0] pat_addr,
    input  logic [NUM_VOICES-1:0]        pat_data,
    input  logic [NUM_VOICES-1:0]        mute,
    output logic [NUM_VOICES-1:0]        trig,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         bar_start,
    output logic                         running
);

    localparam int         PTR_W       = $clog2(NUM_STEPS);
    localparam logic [7:0] C_LAST_TICK = 8'(TICKS_PER_STEP - 1);

    logic                  w_tick_rise;
    ctrl_t                 w_ctrl;
    logic [1:0]            w_next_state;
    logic                  w_rewind;
    logic                  w_count;
    logic                  w_step;

    logic [1:0]            r_state;
    logic [7:0]            r_tick_cnt;
    logic [PTR_W-1:0]      r_play_ptr;
    logic [NUM_VOICES-1:0] r_trig;
    logic                  r_bar;
    logic [NUM_VOICES-1:0] r_pattern [NUM_STEPS];

    tick_edge_sync u_tick_edge_sync (
        .clk_rx    (clk_rx),
        .rst       (rst),
        .tick_in   (tick_in),
        .tick_rise (w_tick_rise)
    );

    always_comb begin
        w_ctrl.start = start;
        w_ctrl.stop  = stop;
        w_ctrl.pause = pause;
        w_next_state = next_state(r_state, w_ctrl);
    end

    // A tick only counts when playback runs both before and after this cycle.
    assign w_rewind = stop || (r_state == C_ST_IDLE && w_next_state == C_ST_RUN);
    assign w_count  = w_tick_rise && (r_state == C_ST_RUN) && (w_next_state == C_ST_RUN);
    assign w_step   = w_count && (r_tick_cnt == C_LAST_TICK);

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            r_state    <= C_ST_IDLE;
            r_tick_cnt <= '0;
            r_play_ptr <= '0;
            r_trig     <= '0;
            r_bar      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_trig  <= '0;
            r_bar   <= 1'b0;
            if (w_rewind) begin
                r_tick_cnt <= '0;
                r_play_ptr <= '0;
            end else if (w_step) begin
                r_tick_cnt <= '0;
                r_play_ptr <= r_play_ptr + 1'b1;
                r_trig     <= r_pattern[r_play_ptr] & ~mute;
                r_bar      <= (r_play_ptr == '0);
            end else if (w_count) begin
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end
        end
    end

    // Non-blocking write: a same-cycle step event still reads the old mask.
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_pattern[i] <= '0;
            end
        end else if (pat_we) begin
            r_pattern[pat_addr] <= pat_data;
        end
    end

    assign trig      = r_trig;
    assign bar_start = r_bar;
    assign step_idx  = r_play_ptr;
    assign running   = (r_state == C_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_drum_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drum_step_sequencer
//  Brief    : Scoreboard bench for drum_step_sequencer with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_drum_step_sequencer;

    logic       clk_rx   = 1'b0;
    logic       rst      = 1'b1;
    logic       tick_in  = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       pause    = 1'b0;
    logic       pat_we   = 1'b0;
    logic [3:0] pat_addr = 4'd0;
    logic [3:0] pat_data = 4'd0;
    logic [3:0] mute     = 4'd0;
    logic [3:0] trig;
    logic [3:0] step_idx;
    logic       bar_start;
    logic       running;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] trig;
        logic       bar;
    } exp_t;
    exp_t exp_q[$];

    drum_step_sequencer dut (
        .clk_rx    (clk_rx),
        .rst       (rst),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .pat_we    (pat_we),
        .pat_addr  (pat_addr),
        .pat_data  (pat_data),
        .mute      (mute),
        .trig      (trig),
        .step_idx  (step_idx),
        .bar_start (bar_start),
        .running   (running)
    );

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) cyc <= cyc + 1;

    // Monitor: every trig/bar_start pulse must match the oldest expectation.
    always @(negedge clk_rx) begin : monitor
        exp_t e;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: nothing seen at cycle %0d, required trig=%b bar=%b",
                         e.cyc, e.trig, e.bar);
            end
            if (trig !== 4'b0000 || bar_start !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cycle %0d trig=%b bar=%b, required none",
                             cyc, trig, bar_start);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.trig !== trig || e.bar !== bar_start) begin
                        errors++;
                        $display("FAIL event: got cycle %0d trig=%b bar=%b, required cycle %0d trig=%b bar=%b",
                                 cyc, trig, bar_start, e.cyc, e.trig, e.bar);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One tick_in period of 8 cycles; the trigger is due 4 edges after the rise.
    task automatic do_tick(input bit ev, input logic [3:0] t, input bit b,
                           input bit wr, input logic [3:0] wa, input logic [3:0] wd);
        exp_t e;
        tick_in = 1'b1;
        if (ev && (t != 4'b0000 || b)) begin
            e.cyc  = cyc + 4;
            e.trig = t;
            e.bar  = b;
            exp_q.push_back(e);
        end
        repeat (3) @(negedge clk_rx);
        if (wr) begin
            pat_we   = 1'b1;
            pat_addr = wa;
            pat_data = wd;
        end
        @(negedge clk_rx);
        pat_we  = 1'b0;
        tick_in = 1'b0;
        repeat (4) @(negedge clk_rx);
    endtask

    task automatic quiet_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic step(input logic [3:0] t, input bit b);
        quiet_ticks(3);
        do_tick(1'b1, t, b, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic ctl(input bit s, input bit p, input bit st);
        start = s;
        pause = p;
        stop  = st;
        @(negedge clk_rx);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic write_pat(input logic [3:0] a, input logic [3:0] d);
        pat_we   = 1'b1;
        pat_addr = a;
        pat_data = d;
        @(negedge clk_rx);
        pat_we   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] t;
        repeat (3) @(negedge clk_rx);
        check("rst_running", running, 0);
        check("rst_step_idx", step_idx, 0);
        rst = 1'b0;
        @(negedge clk_rx);
        check("post_rst_trig", trig, 0);
        check("post_rst_bar", bar_start, 0);
        check("post_rst_running", running, 0);

        // Sparse pattern, one bar
        for (int i = 0; i < 4; i++) write_pat(4'(4 * i), 4'b0001);
        ctl(1'b1, 1'b0, 1'b0);
        check("t1_running", running, 1);
        check("t1_step_idx", step_idx, 0);
        for (int s = 0; s < 16; s++) step((s % 4 == 0) ? 4'b0001 : 4'b0000, s == 0);
        check("t1_wrap", step_idx, 0);

        // Full pattern with voice 2 muted
        for (int i = 0; i < 16; i++) write_pat(4'(i), 4'b1111);
        mute = 4'b0100;
        for (int s = 0; s < 16; s++) begin
            step(4'b1011, s == 0);
            check("t2_step_idx", step_idx, (s + 1) % 16);
        end

        // Pause mid-step, ticks discarded, resume finishes the step
        for (int s = 0; s < 6; s++) step(4'b1011, s == 0);
        quiet_ticks(2);
        ctl(1'b0, 1'b1, 1'b0);
        check("t3_paused_running", running, 0);
        check("t3_paused_idx", step_idx, 6);
        quiet_ticks(10);
        check("t3_still_idx", step_idx, 6);
        ctl(1'b1, 1'b0, 1'b0);
        check("t3_resumed_running", running, 1);
        quiet_ticks(1);
        do_tick(1'b1, 4'b1011, 1'b0, 1'b0, 4'd0, 4'd0);
        check("t3_after_idx", step_idx, 7);
        ctl(1'b1, 1'b1, 1'b0);
        check("pause_over_start", running, 0);
        check("pause_over_start_idx", step_idx, 7);
        ctl(1'b1, 1'b0, 1'b0);
        check("resume_running", running, 1);

        // All three pulses together: stop wins
        ctl(1'b1, 1'b1, 1'b1);
        check("t4_running", running, 0);
        check("t4_step_idx", step_idx, 0);
        quiet_ticks(4);
        check("t4_idle_idx", step_idx, 0);
        check("t4_idle_running", running, 0);

        // Write collides with step-3 event: old mask now, new mask next pass
        write_pat(4'd3, 4'b0010);
        mute = 4'b0000;
        ctl(1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < ((p == 0) ? 16 : 4); s++) begin
                if (s == 3) t = (p == 0) ? 4'b0010 : 4'b1000;
                else        t = 4'b1111;
                if (p == 0 && s == 3) begin
                    quiet_ticks(3);
                    do_tick(1'b1, t, 1'b0, 1'b1, 4'd3, 4'b1000);
                end else begin
                    step(t, s == 0);
                end
            end
        end
        check("t5_step_idx", step_idx, 4);

        // Asynchronous reset right after a step-4 trigger appears
        quiet_ticks(3);
        tick_in = 1'b1;
        repeat (4) @(posedge clk_rx);
        #1;
        check("pre_rst_trig", trig, 4'b1111);
        rst = 1'b1;
        #1;
        check("async_rst_trig", trig, 0);
        check("async_rst_bar", bar_start, 0);
        check("async_rst_running", running, 0);
        check("async_rst_idx", step_idx, 0);
        @(posedge clk_rx);
        #1;
        rst = 1'b0;
        @(negedge clk_rx);
        tick_in = 1'b0;
        repeat (4) @(negedge clk_rx);
        quiet_ticks(4);
        check("t6_idle_running", running, 0);
        ctl(1'b1, 1'b0, 1'b0);
        // Cleared pattern: only the bar marker on step 0
        for (int s = 0; s < 16; s++) step(4'b0000, s == 0);
        check("t6_step_idx", step_idx, 0);

        repeat (10) @(negedge clk_rx);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
